adc_conv_host: RTL and testbench

ADC_CONV_HOST -- requirements
Module: adc_conv_host

---
 rtl/adc_host_pkg.sv | 24 ++
 rtl/adc_conv_host_if.sv | 25 ++
 rtl/sync_edge.sv | 32 +++
 rtl/adc_conv_host.sv | 148 ++++++++++++++
 tb/tb_adc_conv_host.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_host_pkg.sv
// Shared definitions for the ADC conversion host: controller states,
// default timing constants and the result width.
package adc_host_pkg;

    localparam int RES_W      = 10;   // ADC result width
    localparam int SAMPLE_DEF = 8;    // default sample-phase length (clk cycles)
    localparam int TIMEOUT    = 255;  // max wait for adc_done after st_conv falls
    localparam int SYNC_DEF   = 2;    // default adc_done synchronizer depth

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_SAMPLE  = 3'd2,
        S_CONV    = 3'd3,
        S_CAPTURE = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    // Sample-phase length: a programmed value of zero selects the default.
    function automatic logic [7:0] eff_sample(input logic [7:0] n, input logic [7:0] def_n);
        return (n == 8'd0) ? def_n : n;
    endfunction

endpackage

// File: rtl/adc_conv_host_if.sv
// ADC pin bundle plus the valid/ready result channel.
// master = the conversion host, slave = the ADC / result consumer side.
interface adc_conv_host_if;
    import adc_host_pkg::*;

    logic             st_conv;
    logic             adc_cal;
    logic             adc_rst;
    logic             adc_done;
    logic [RES_W-1:0] adc_result;
    logic [RES_W-1:0] data_out;
    logic             data_valid;
    logic             data_ready;

    modport master (
        output st_conv, adc_cal, adc_rst, data_out, data_valid,
        input  adc_done, adc_result, data_ready
    );

    modport slave (
        input  st_conv, adc_cal, adc_rst, data_out, data_valid,
        output adc_done, adc_result, data_ready
    );

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, followed by a
// rising-edge detector producing a one-cycle pulse in the clk domain.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Shift the async level through the synchronizer chain, remember last value.
    // NOTE: flops are written with <= so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/adc_conv_host.sv
// Conversion sequencer for an external ADC: sample/convert strobing,
// calibration requests, done timeout, and a valid/ready result register.
module adc_conv_host #(
    parameter int SAMPLE_DEF  = adc_host_pkg::SAMPLE_DEF,
    parameter int TIMEOUT     = adc_host_pkg::TIMEOUT,
    parameter int SYNC_STAGES = adc_host_pkg::SYNC_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_enable,
    input  logic                   i_single,
    input  logic                   i_cal_req,
    input  logic [7:0]             i_sample_cycles,
    input  logic [15:0]            i_period_cycles,
    adc_conv_host_if.master        io_adc,
    output logic                   o_busy,
    output logic                   o_timeout_err,
    output logic                   o_overrun
);
    import adc_host_pkg::*;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [7:0]  SAMPLE_DEF_N = 8'(SAMPLE_DEF);

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_cnt;        // cycles spent in the current state
    logic [15:0]      r_since;      // cycles since st_conv last rose
    logic [7:0]       r_n_sample;   // sample length latched at S_SAMPLE entry
    logic             r_cal_pend;   // calibration requested, not yet completed
    logic             r_cal_run;    // the conversion in flight is a calibration
    logic [RES_W-1:0] r_data;
    logic             r_valid;
    logic             r_timeout_err;
    logic             r_overrun;

    logic             w_done_rise;
    logic             w_enter_sample;
    logic             w_accept;
    logic             w_timeout;

    sync_edge #(.STAGES(SYNC_STAGES)) u_done_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (io_adc.adc_done),
        .o_rise (w_done_rise)
    );

    assign w_enter_sample = (w_next == S_SAMPLE) && (r_state != S_SAMPLE);
    assign w_accept       = r_valid && io_adc.data_ready;
    assign w_timeout      = (r_state == S_CONV) && (w_next == S_IDLE);

    // Next-state decode.
    // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:    if (r_cnt == 16'd1) w_next = S_IDLE;
            S_IDLE:    if (i_enable || i_single) w_next = S_SAMPLE;
            S_SAMPLE:  if (r_cnt == {8'd0, r_n_sample} - 16'd1) w_next = S_CONV;
            S_CONV: begin
                if (w_done_rise)                w_next = S_CAPTURE;
                else if (r_cnt == TIMEOUT_LAST) w_next = S_IDLE;
            end
            S_CAPTURE: w_next = i_enable ? S_GAP : S_IDLE;
            S_GAP: begin
                // Leave once the next cycle would land on the programmed period.
                if (({1'b0, r_since} + 17'd1) >= {1'b0, i_period_cycles})
                    w_next = i_enable ? S_SAMPLE : S_IDLE;
            end
            default:   w_next = S_INIT;
        endcase
    end

    // State register; reset aborts any conversion and re-runs the ADC reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_INIT;
        else     r_state <= w_next;
    end

    // Per-state cycle counter and period counter, both saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_since    <= '0;
            r_n_sample <= '0;
        end else begin
            if (w_next != r_state)    r_cnt <= '0;
            else if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;

            if (w_enter_sample) begin
                r_since    <= '0;
                r_n_sample <= eff_sample(i_sample_cycles, SAMPLE_DEF_N);
            end else if (r_since != 16'hFFFF) begin
                r_since <= r_since + 16'd1;
            end
        end
    end

    // Calibration bookkeeping: a request is held until a calibration conversion completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cal_pend <= 1'b0;
            r_cal_run  <= 1'b0;
        end else begin
            if (i_cal_req)                                r_cal_pend <= 1'b1;
            else if (r_state == S_CAPTURE && r_cal_run)   r_cal_pend <= 1'b0;

            if (w_enter_sample)                           r_cal_run <= r_cal_pend | i_cal_req;
            else if (r_state == S_CAPTURE || w_timeout)   r_cal_run <= 1'b0;
        end
    end

    // Result register, valid/ready handshake and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (r_state == S_CAPTURE && !r_cal_run) begin
                // A word consumed this very cycle frees the slot for the new one.
                if (!r_valid || w_accept) begin
                    r_data  <= io_adc.adc_result;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end

            if (w_timeout) r_timeout_err <= 1'b1;
        end
    end

    // Pin outputs decode straight from state so reset drops st_conv immediately.
    assign io_adc.st_conv    = (r_state == S_SAMPLE);
    assign io_adc.adc_rst    = (r_state == S_INIT);
    assign io_adc.adc_cal    = r_cal_run;
    assign io_adc.data_out   = r_data;
    assign io_adc.data_valid = r_valid;
    assign o_busy            = (r_state != S_IDLE);
    assign o_timeout_err     = r_timeout_err;
    assign o_overrun         = r_overrun;

endmodule

// File: tb/tb_adc_conv_host.sv
// Directed bench for adc_conv_host: reset sequence, single-shot capture,
// overrun, calibration, free-running period, enable drop, timeout, async reset.
module tb_adc_conv_host;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        single;
    logic        cal_req;
    logic [7:0]  sample_cycles;
    logic [15:0] period_cycles;
    logic        busy;
    logic        timeout_err;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    adc_conv_host_if bus ();

    adc_conv_host dut (
        .clk             (clk),
        .rst             (rst),
        .i_enable        (enable),
        .i_single        (single),
        .i_cal_req       (cal_req),
        .i_sample_cycles (sample_cycles),
        .i_period_cycles (period_cycles),
        .io_adc          (bus),
        .o_busy          (busy),
        .o_timeout_err   (timeout_err),
        .o_overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_single();
        single = 1'b1;
        tick(1);
        single = 1'b0;
    endtask

    // Wait (bounded) until st_conv reaches the wanted level.
    task automatic wait_st(input string tag, input logic want);
        int k = 0;
        while (bus.st_conv !== want && k < 400) begin
            tick(1);
            k++;
        end
        check(tag, 32'(bus.st_conv), 32'(want));
    endtask

    // Wait (bounded) for data_valid to go high.
    task automatic wait_valid(input string tag);
        int k = 0;
        while (bus.data_valid !== 1'b1 && k < 30) begin
            tick(1);
            k++;
        end
        check(tag, 32'(bus.data_valid), 32'd1);
    endtask

    initial begin
        int k;
        int t0, t1, t2;
        logic seen;

        rst           = 1'b1;
        enable        = 1'b0;
        single        = 1'b0;
        cal_req       = 1'b0;
        sample_cycles = 8'd4;
        period_cycles = 16'd0;
        bus.adc_done   = 1'b0;
        bus.adc_result = '0;
        bus.data_ready = 1'b0;
        tick(3);

        // Reset state
        check("rst_st_conv", 32'(bus.st_conv), 32'd0);
        check("rst_adc_rst", 32'(bus.adc_rst), 32'd1);
        check("rst_busy",    32'(busy),        32'd1);
        check("rst_valid",   32'(bus.data_valid), 32'd0);
        check("rst_data",    32'(bus.data_out), 32'd0);
        check("rst_errs",    {30'd0, timeout_err, overrun}, 32'd0);

        // ADC reset held two cycles after release
        rst = 1'b0;
        tick(1);
        check("init_adc_rst_c1", 32'(bus.adc_rst), 32'd1);
        tick(1);
        check("init_adc_rst_done", 32'(bus.adc_rst), 32'd0);
        check("init_idle_busy",    32'(busy),        32'd0);
        check("init_st_conv",      32'(bus.st_conv), 32'd0);

        // Single conversion, 4-cycle sample, done 20 cycles after the fall
        pulse_single();
        k = 0;
        while (bus.st_conv === 1'b1 && k < 300) begin
            k++;
            tick(1);
        end
        check("single_sample_len", 32'(k), 32'd4);
        tick(19);
        bus.adc_result = 10'h2A5;
        bus.adc_done   = 1'b1;
        wait_valid("single_valid_wait");
        check("single_data", 32'(bus.data_out), 32'h2A5);
        check("single_idle", 32'(busy), 32'd0);
        check("single_no_cal", 32'(bus.adc_cal), 32'd0);
        bus.adc_done = 1'b0;
        tick(2);

        // Second conversion with data_ready low -> overrun, old word kept
        pulse_single();
        wait_st("ovr_fall", 1'b0);
        bus.adc_result = 10'h155;
        bus.adc_done   = 1'b1;
        tick(6);
        bus.adc_done = 1'b0;
        tick(2);
        check("ovr_flag",  32'(overrun),        32'd1);
        check("ovr_data",  32'(bus.data_out),   32'h2A5);
        check("ovr_valid", 32'(bus.data_valid), 32'd1);

        // Handshake clears valid the cycle after; overrun is sticky
        bus.data_ready = 1'b1;
        tick(1);
        check("hs_valid_clear", 32'(bus.data_valid), 32'd0);
        check("hs_ovr_sticky",  32'(overrun),        32'd1);

        // Calibration conversion: adc_cal through the conversion, result discarded
        cal_req = 1'b1;
        tick(1);
        cal_req = 1'b0;
        tick(3);
        check("cal_pending_idle", 32'(bus.adc_cal), 32'd0);
        pulse_single();
        check("cal_in_sample", 32'(bus.adc_cal), 32'd1);
        wait_st("cal_fall", 1'b0);
        check("cal_in_conv", 32'(bus.adc_cal), 32'd1);
        bus.adc_result = 10'h3FF;
        bus.adc_done   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            seen = seen | bus.data_valid;
        end
        bus.adc_done = 1'b0;
        check("cal_no_valid", 32'(seen),         32'd0);
        check("cal_released", 32'(bus.adc_cal),  32'd0);
        check("cal_data_kept", 32'(bus.data_out), 32'h2A5);
        tick(2);

        // Following conversion is normal again
        pulse_single();
        check("post_cal_no_cal", 32'(bus.adc_cal), 32'd0);
        wait_st("post_cal_fall", 1'b0);
        bus.adc_result = 10'h0C3;
        bus.adc_done   = 1'b1;
        wait_valid("post_cal_valid");
        check("post_cal_data", 32'(bus.data_out), 32'h0C3);
        tick(1);
        check("post_cal_valid_clear", 32'(bus.data_valid), 32'd0);
        bus.adc_done = 1'b0;
        tick(2);

        // Free-running: st_conv rising edges exactly period_cycles apart
        period_cycles = 16'd100;
        enable        = 1'b1;
        wait_st("per_rise0", 1'b1);
        t0 = cyc;
        wait_st("per_fall0", 1'b0);
        bus.adc_result = 10'h011;
        bus.adc_done   = 1'b1;
        tick(6);
        bus.adc_done = 1'b0;
        wait_st("per_rise1", 1'b1);
        t1 = cyc;
        wait_st("per_fall1", 1'b0);
        bus.adc_done = 1'b1;
        tick(6);
        bus.adc_done = 1'b0;
        wait_st("per_rise2", 1'b1);
        t2 = cyc;
        check("per_interval1", 32'(t1 - t0), 32'd100);
        check("per_interval2", 32'(t2 - t1), 32'd100);

        // Drop enable mid-sample: conversion completes, then idle
        enable = 1'b0;
        wait_st("drop_fall", 1'b0);
        bus.adc_result = 10'h1AB;
        bus.adc_done   = 1'b1;
        wait_valid("drop_valid");
        check("drop_data", 32'(bus.data_out), 32'h1AB);
        bus.adc_done = 1'b0;
        tick(2);
        check("drop_idle", 32'(busy), 32'd0);
        k = 0;
        for (int i = 0; i < 150; i++) begin
            tick(1);
            if (bus.st_conv === 1'b1) k++;
        end
        check("drop_no_restart", 32'(k), 32'd0);

        // Timeout: adc_done never comes; flag set exactly TIMEOUT cycles after the fall
        pulse_single();
        wait_st("to_fall", 1'b0);
        tick(254);
        check("to_before_flag", 32'(timeout_err), 32'd0);
        check("to_before_busy", 32'(busy),        32'd1);
        tick(1);
        check("to_flag", 32'(timeout_err), 32'd1);
        check("to_idle", 32'(busy),        32'd0);
        tick(3);
        check("to_sticky", 32'(timeout_err), 32'd1);

        // Reset mid-sample drops st_conv without waiting for a clock edge
        pulse_single();
        check("arst_pre_st_conv", 32'(bus.st_conv), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_st_conv", 32'(bus.st_conv), 32'd0);
        check("arst_adc_rst", 32'(bus.adc_rst), 32'd1);
        check("arst_errs",    {30'd0, timeout_err, overrun}, 32'd0);
        check("arst_data",    32'(bus.data_out), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(3);
        check("arst_recover_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
